// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch unit placed directly in front of the RAM block. It walks an
// 8-bit program counter through program space, reads the opcode byte plus up to
// two operand bytes, and presents the assembled instruction to the execute
// stage over a valid/ready handshake. While an instruction is held, the unit
// lets go of the RAM controls so the execute stage can make data accesses.
//
// Each byte takes two cycles: ADDR loads the RAM address register, DATA
// captures the combinational read data from that registered address.
//
// Ports:
//   i_clk            system clock, rising-edge active
//   i_reset          synchronous, active-high reset
//   o_address        RAM address (program counter while fetching, else 0)
//   o_addressEn      RAM address register load enable
//   o_readDataSelect RAM space select (0 = program space)
//   o_outEnable      RAM output enable
//   i_readData       RAM read data
//   o_busOwn         1 while the fetch unit drives the RAM controls
//   o_instrValid     assembled instruction available
//   i_instrReady     execute stage accepts the held instruction
//   o_opcode         opcode byte
//   o_operand1       first operand byte (0 if unused)
//   o_operand2       second operand byte (0 if unused)
//   o_length         instruction length in bytes (1..3)
//   o_pc             address of the held opcode
//   i_jump           redirect request, honoured only on a handshake
//   i_jumpAddr       redirect target
// ----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset,
    output logic [7:0] o_address,
    output logic       o_addressEn,
    output logic       o_readDataSelect,
    output logic       o_outEnable,
    input  logic [7:0] i_readData,
    output logic       o_busOwn,
    output logic       o_instrValid,
    input  logic       i_instrReady,
    output logic [7:0] o_opcode,
    output logic [7:0] o_operand1,
    output logic [7:0] o_operand2,
    output logic [1:0] o_length,
    output logic [7:0] o_pc,
    input  logic       i_jump,
    input  logic [7:0] i_jumpAddr
);

    typedef enum logic [1:0] {
        StAddr,
        StData,
        StValid
    } state_e;

    state_e     r_state;
    state_e     w_state_next;

    logic [7:0] r_pc;
    logic [1:0] r_cnt;
    logic [7:0] r_opcode;
    logic [7:0] r_operand1;
    logic [7:0] r_operand2;
    logic [1:0] r_length;
    logic [7:0] r_instr_pc;

    logic [1:0] w_dec_len;
    logic [1:0] w_cur_len;
    logic [1:0] w_cnt_inc;
    logic       w_last_byte;
    logic       w_handshake;

    // Length from opcode[7:6]: 00 -> 1, 01 -> 2, 1x -> 3.
    always_comb begin
        w_dec_len = 2'd3;
        unique case (i_readData[7:6])
            2'b00:   w_dec_len = 2'd1;
            2'b01:   w_dec_len = 2'd2;
            default: w_dec_len = 2'd3;
        endcase
    end

    // On the opcode byte the stored length is not yet valid, so use the
    // freshly decoded one; later bytes use the value latched at the opcode.
    assign w_cur_len   = (r_cnt == 2'd0) ? w_dec_len : r_length;
    assign w_cnt_inc   = r_cnt + 2'd1;
    assign w_last_byte = (w_cnt_inc == w_cur_len);
    assign w_handshake = (r_state == StValid) && i_instrReady;

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StAddr;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StAddr:  w_state_next = StData;
            StData:  w_state_next = w_last_byte ? StValid : StAddr;
            StValid: w_state_next = w_handshake ? StAddr : StValid;
            default: w_state_next = StAddr;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        o_address        = 8'h00;
        o_addressEn      = 1'b0;
        o_readDataSelect = 1'b0;
        o_outEnable      = 1'b0;
        o_busOwn         = 1'b0;
        o_instrValid     = 1'b0;
        case (r_state)
            StAddr: begin
                o_busOwn    = 1'b1;
                o_addressEn = 1'b1;
                o_address   = r_pc;
            end
            StData: begin
                o_busOwn    = 1'b1;
                o_outEnable = 1'b1;
                o_address   = r_pc;
            end
            StValid: begin
                // Bus released: all RAM controls low for the execute stage.
                o_instrValid = 1'b1;
            end
            default: begin
                o_busOwn = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: program counter, byte counter and instruction registers
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc       <= RESET_PC;
            r_cnt      <= 2'd0;
            r_opcode   <= 8'h00;
            r_operand1 <= 8'h00;
            r_operand2 <= 8'h00;
            r_length   <= 2'd0;
            r_instr_pc <= 8'h00;
        end else begin
            case (r_state)
                StData: begin
                    // 8-bit wrap lets operands straddle 0xFF -> 0x00.
                    r_pc <= r_pc + 8'd1;
                    unique case (r_cnt)
                        2'd0: begin
                            r_opcode   <= i_readData;
                            r_operand1 <= 8'h00;
                            r_operand2 <= 8'h00;
                            r_length   <= w_dec_len;
                            r_instr_pc <= r_pc;
                        end
                        2'd1:    r_operand1 <= i_readData;
                        default: r_operand2 <= i_readData;
                    endcase
                    if (!w_last_byte) begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                StValid: begin
                    if (w_handshake) begin
                        r_cnt <= 2'd0;
                        if (i_jump) begin
                            r_pc <= i_jumpAddr;
                        end
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign o_opcode   = r_opcode;
    assign o_operand1 = r_operand1;
    assign o_operand2 = r_operand2;
    assign o_length   = r_length;
    assign o_pc       = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch
//
// Self-checking bench for instr_fetch. Two instances share the clock: dut0
// with RESET_PC = 0x00 and dut1 with RESET_PC = 0xFE for the wrap case. Each
// has a small RAM model (registered address, combinational read data).
// Expected instructions are queued when a scenario is set up and popped when
// the DUT raises o_instrValid. Inputs are driven and outputs sampled on the
// falling edge.
// ----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int MaxWait = 20;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] op1;
        logic [7:0] op2;
        logic [1:0] len;
        logic [7:0] pc;
    } instr_t;

    logic clk;

    // dut0 signals
    logic       rst0, rdy0, jmp0;
    logic [7:0] jaddr0, addr0, rdata0, opc0, opa0, opb0, pc0;
    logic       aen0, rds0, oen0, bus0, vld0;
    logic [1:0] len0;
    // dut1 signals
    logic       rst1, rdy1, jmp1;
    logic [7:0] jaddr1, addr1, rdata1, opc1, opa1, opb1, pc1;
    logic       aen1, rds1, oen1, bus1, vld1;
    logic [1:0] len1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];
    logic [7:0] raddr0, raddr1;

    instr_t sb0[$];
    instr_t sb1[$];

    int vectors    = 0;
    int miscompares = 0;

    instr_fetch #(.RESET_PC(8'h00)) dut0 (
        .i_clk(clk), .i_reset(rst0),
        .o_address(addr0), .o_addressEn(aen0), .o_readDataSelect(rds0),
        .o_outEnable(oen0), .i_readData(rdata0), .o_busOwn(bus0),
        .o_instrValid(vld0), .i_instrReady(rdy0),
        .o_opcode(opc0), .o_operand1(opa0), .o_operand2(opb0),
        .o_length(len0), .o_pc(pc0), .i_jump(jmp0), .i_jumpAddr(jaddr0)
    );

    instr_fetch #(.RESET_PC(8'hFE)) dut1 (
        .i_clk(clk), .i_reset(rst1),
        .o_address(addr1), .o_addressEn(aen1), .o_readDataSelect(rds1),
        .o_outEnable(oen1), .i_readData(rdata1), .o_busOwn(bus1),
        .o_instrValid(vld1), .i_instrReady(rdy1),
        .o_opcode(opc1), .o_operand1(opa1), .o_operand2(opb1),
        .o_length(len1), .o_pc(pc1), .i_jump(jmp1), .i_jumpAddr(jaddr1)
    );

    // RAM models: address register loads on addressEn, data read through it.
    always @(posedge clk) begin
        if (aen0) raddr0 <= addr0;
        if (aen1) raddr1 <= addr1;
    end
    assign rdata0 = mem0[raddr0];
    assign rdata1 = mem1[raddr1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t obs0();
        return '{opcode: opc0, op1: opa0, op2: opb0, len: len0, pc: pc0};
    endfunction

    function automatic instr_t obs1();
        return '{opcode: opc1, op1: opa1, op2: opb1, len: len1, pc: pc1};
    endfunction

    // Wait (bounded) for o_instrValid; n counts falling edges since ADDR.
    task automatic wait_valid0(input int start, output int n);
        n = start;
        while (vld0 !== 1'b1 && n < MaxWait) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic wait_valid1(input int start, output int n);
        n = start;
        while (vld1 !== 1'b1 && n < MaxWait) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [51:0] got, exp;
        rst0 = 1'b1; rdy0 = 1'b0; jmp0 = 1'b0; jaddr0 = 8'h00;
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        got = {addr0, aen0, rds0, oen0, bus0, vld0, obs0()};
        exp = {8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL reset_state: got %h, expected %h", got, exp);
        end
    endtask

    task automatic test_single_byte();
        int     n;
        instr_t exp;
        sb0.push_back('{opcode: 8'h12, op1: 8'h00, op2: 8'h00, len: 2'd1, pc: 8'h00});
        rdy0 = 1'b1;
        wait_valid0(0, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL single_latency: got %0d, expected 2", n);
        end
        exp = sb0.pop_front();
        vectors++;
        if (obs0() !== exp) begin
            miscompares++;
            $display("FAIL single_instr: got %h, expected %h", obs0(), exp);
        end
        @(negedge clk);
        rdy0 = 1'b0;
        vectors++;
        if (addr0 !== 8'h01 || aen0 !== 1'b1) begin
            miscompares++;
            $display("FAIL single_next_addr: got %h/%b, expected 01/1", addr0, aen0);
        end
    endtask

    task automatic test_three_byte_hold();
        int          n;
        instr_t      exp;
        logic [47:0] got, want;
        sb0.push_back('{opcode: 8'h85, op1: 8'hAA, op2: 8'h55, len: 2'd3, pc: 8'h01});
        wait_valid0(0, n);
        vectors++;
        if (n !== 6) begin
            miscompares++;
            $display("FAIL three_latency: got %0d, expected 6", n);
        end
        exp = sb0.pop_front();
        vectors++;
        if (obs0() !== exp) begin
            miscompares++;
            $display("FAIL three_instr: got %h, expected %h", obs0(), exp);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            got  = {obs0(), vld0, bus0, aen0, oen0, rds0, addr0};
            want = {exp, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL three_hold[%0d]: got %h, expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_jump();
        int     n;
        instr_t exp;
        rdy0 = 1'b1; jmp0 = 1'b1; jaddr0 = 8'h40;
        @(negedge clk);
        vectors++;
        if (addr0 !== 8'h40 || aen0 !== 1'b1) begin
            miscompares++;
            $display("FAIL jump_target: got %h/%b, expected 40/1", addr0, aen0);
        end
        // Redirect and ready pulsed while fetching must be ignored.
        sb0.push_back('{opcode: 8'h4C, op1: 8'h77, op2: 8'h00, len: 2'd2, pc: 8'h40});
        jaddr0 = 8'h80;
        @(negedge clk);
        jmp0 = 1'b0; rdy0 = 1'b0;
        wait_valid0(1, n);
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL two_latency: got %0d, expected 4", n);
        end
        exp = sb0.pop_front();
        vectors++;
        if (obs0() !== exp) begin
            miscompares++;
            $display("FAIL two_instr: got %h, expected %h", obs0(), exp);
        end
        rdy0 = 1'b1;
        @(negedge clk);
        vectors++;
        if (addr0 !== 8'h42) begin
            miscompares++;
            $display("FAIL no_jump_next_addr: got %h, expected 42", addr0);
        end
    endtask

    task automatic test_reset_mid_fetch();
        int          n;
        instr_t      exp;
        logic [51:0] got, want;
        rdy0 = 1'b0;
        repeat (3) @(negedge clk);   // DATA, ADDR, DATA of operand1
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        got  = {addr0, aen0, rds0, oen0, bus0, vld0, obs0()};
        want = {8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL midfetch_reset_state: got %h, expected %h", got, want);
        end
        sb0.push_back('{opcode: 8'h12, op1: 8'h00, op2: 8'h00, len: 2'd1, pc: 8'h00});
        wait_valid0(0, n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL midfetch_restart_latency: got %0d, expected 2", n);
        end
        exp = sb0.pop_front();
        vectors++;
        if (obs0() !== exp) begin
            miscompares++;
            $display("FAIL midfetch_restart_instr: got %h, expected %h", obs0(), exp);
        end
    endtask

    task automatic test_back_to_back();
        int     n;
        instr_t exp;
        for (int i = 0; i < 4; i++) begin
            sb0.push_back('{opcode: 8'(8'h01 + i), op1: 8'h00, op2: 8'h00, len: 2'd1,
                            pc: 8'(8'h80 + i)});
        end
        rdy0 = 1'b1; jmp0 = 1'b1; jaddr0 = 8'h80;
        @(negedge clk);
        jmp0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wait_valid0(0, n);
            vectors++;
            if (n !== 2) begin
                miscompares++;
                $display("FAIL b2b_latency[%0d]: got %0d, expected 2", i, n);
            end
            exp = sb0.pop_front();
            vectors++;
            if (obs0() !== exp) begin
                miscompares++;
                $display("FAIL b2b_instr[%0d]: got %h, expected %h", i, obs0(), exp);
            end
            @(negedge clk);
        end
        rdy0 = 1'b0;
    endtask

    task automatic test_pc_wrap();
        int          n;
        instr_t      exp;
        logic [51:0] got, want;
        @(negedge clk);
        rst1 = 1'b0;
        got  = {addr1, aen1, rds1, oen1, bus1, vld1, obs1()};
        want = {8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 34'h0};
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL wrap_reset_state: got %h, expected %h", got, want);
        end
        sb1.push_back('{opcode: 8'h41, op1: 8'h33, op2: 8'h00, len: 2'd2, pc: 8'hFE});
        sb1.push_back('{opcode: 8'h99, op1: 8'h11, op2: 8'h22, len: 2'd3, pc: 8'h00});
        rdy1 = 1'b1;
        wait_valid1(0, n);
        vectors++;
        if (n !== 4) begin
            miscompares++;
            $display("FAIL wrap_two_latency: got %0d, expected 4", n);
        end
        exp = sb1.pop_front();
        vectors++;
        if (obs1() !== exp) begin
            miscompares++;
            $display("FAIL wrap_two_instr: got %h, expected %h", obs1(), exp);
        end
        @(negedge clk);
        vectors++;
        if (addr1 !== 8'h00) begin
            miscompares++;
            $display("FAIL wrap_next_addr: got %h, expected 00", addr1);
        end
        wait_valid1(0, n);
        vectors++;
        if (n !== 6) begin
            miscompares++;
            $display("FAIL wrap_three_latency: got %0d, expected 6", n);
        end
        exp = sb1.pop_front();
        vectors++;
        if (obs1() !== exp) begin
            miscompares++;
            $display("FAIL wrap_three_instr: got %h, expected %h", obs1(), exp);
        end
        @(negedge clk);
        rdy1 = 1'b0;
        vectors++;
        if (addr1 !== 8'h03) begin
            miscompares++;
            $display("FAIL wrap_after_addr: got %h, expected 03", addr1);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end
        mem0[8'h00] = 8'h12;
        mem0[8'h01] = 8'h85; mem0[8'h02] = 8'hAA; mem0[8'h03] = 8'h55;
        mem0[8'h40] = 8'h4C; mem0[8'h41] = 8'h77;
        mem0[8'h42] = 8'h9A; mem0[8'h43] = 8'h01; mem0[8'h44] = 8'h02;
        mem0[8'h80] = 8'h01; mem0[8'h81] = 8'h02; mem0[8'h82] = 8'h03; mem0[8'h83] = 8'h04;
        mem1[8'hFE] = 8'h41; mem1[8'hFF] = 8'h33;
        mem1[8'h00] = 8'h99; mem1[8'h01] = 8'h11; mem1[8'h02] = 8'h22;

        rst0 = 1'b1; rdy0 = 1'b0; jmp0 = 1'b0; jaddr0 = 8'h00;
        rst1 = 1'b1; rdy1 = 1'b0; jmp1 = 1'b0; jaddr1 = 8'h00;

        test_reset();
        test_single_byte();
        test_three_byte_hold();
        test_jump();
        test_reset_mid_fetch();
        test_back_to_back();
        test_pc_wrap();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction fetch unit sitting directly upstream of the RAM block. It owns the RAM address/read controls while fetching.
- Holds an 8-bit program counter and reads 1-3 instruction bytes from program space: the opcode plus up to two operands.
- Presents the assembled instruction to the execute stage with a valid/ready handshake.
- Releases the memory bus while an instruction is held, so the execute stage can perform data accesses.

Parameters:
RESET_PC, 8'h00, program counter value loaded on reset.

Ports:
i_clk  input  1  system clock; all state changes on the rising edge.
i_reset  input  1  synchronous, active-high reset.
o_address  output  8  address to RAM.
o_addressEn  output  1  RAM address register load enable.
o_readDataSelect  output  1  RAM space select; always 0 (program) whenever o_busOwn=1.
o_outEnable  output  1  RAM output enable.
i_readData  input  8  RAM read data; combinational from the RAM's registered address.
o_busOwn  output  1  1 = fetch unit drives the RAM controls; 0 = bus free for execute.
o_instrValid  output  1  assembled instruction available.
i_instrReady  input  1  execute stage consumes the instruction.
o_opcode  output  8  opcode byte.
o_operand1  output  8  first operand; 0 if unused.
o_operand2  output  8  second operand; 0 if unused.
o_length  output  2  instruction length in bytes: 1, 2 or 3.
o_pc  output  8  address of the held opcode.
i_jump  input  1  redirect; sampled only on a handshake.
i_jumpAddr  input  8  redirect target.

Behaviour:
- Length decode from opcode[7:6]:
  - 00 -> 1 byte
  - 01 -> 2 bytes
  - 10 or 11 -> 3 bytes
- States: ADDR, DATA, VALID. Byte counter cnt runs 0..2 and selects the destination: opcode, operand1 or operand2.
- Reset (i_reset=1 at an edge), regardless of state, including mid-fetch:
  - pc=RESET_PC, state=ADDR, cnt=0.
  - opcode, operands, o_length and o_pc = 0.
  - o_instrValid=0.
- ADDR state:
  - Outputs: o_busOwn=1, o_addressEn=1, o_address=pc, o_outEnable=0, o_readDataSelect=0.
  - Next state: DATA.
- DATA state:
  - Outputs: o_busOwn=1, o_addressEn=0, o_address=pc, o_outEnable=1, o_readDataSelect=0.
  - At the edge, i_readData is captured into the byte selected by cnt, and pc <= pc+1 (8-bit wrap, 0xFF -> 0x00).
  - When cnt=0: o_pc <= pc, operands <= 0, o_length <= decoded length.
  - If cnt+1 equals the decoded length, go to VALID; otherwise cnt++ and go to ADDR.
  - The length used is the one decoded from the byte captured at cnt=0.
- VALID state:
  - Outputs: o_instrValid=1, o_busOwn=0; o_addressEn, o_outEnable, o_readDataSelect and o_address all 0.
  - Instruction outputs are held stable until the handshake.
  - Handshake = o_instrValid & i_instrReady at an edge. On it: o_instrValid <= 0, cnt <= 0, state ADDR.
  - On the handshake, pc <= i_jump ? i_jumpAddr : pc.
- i_instrReady and i_jump are ignored outside VALID.
- Latency from entering ADDR to o_instrValid=1:
  - 1-byte instruction: 2 cycles.
  - 2-byte instruction: 4 cycles.
  - 3-byte instruction: 6 cycles.
  - Minimum back-to-back issue rate: one 1-byte instruction per 3 cycles (VALID + ADDR + DATA).
- Operand fetch continues across the 0xFF -> 0x00 wrap. o_pc reports the opcode address.
- If i_reset and a handshake coincide, reset wins.

Test Plan:
- Reset -> all outputs 0 except o_address=RESET_PC, o_busOwn=1, o_addressEn=1 in the first cycle after reset deasserts.
- Memory 0x00=0x12, ready held 1 -> o_instrValid=1 at cycle 2 with opcode 0x12, o_length=1, operands 0, o_pc 0x00; next fetch at o_address 0x01.
- Memory 0x01..0x03 = 0x85,0xAA,0x55 -> valid 6 cycles after ADDR; opcode 0x85, op1 0xAA, op2 0x55, length 3, o_pc 0x01. Hold ready=0 for 5 cycles -> outputs stable and o_busOwn=0 throughout.
- Handshake with i_jump=1, i_jumpAddr=0x40 -> next ADDR drives o_address 0x40. i_jump pulsed outside VALID -> no effect.
- RESET_PC=0xFE, 0xFE=0x41, 0xFF=0x33, 0x00=0x99 -> 2-byte instruction (op1 0x33). Next opcode is fetched from 0x00 (0x99 -> 3-byte, operands from 0x01, 0x02).
- Assert i_reset during DATA of operand1 -> the next cycle shows the reset state, and the fetch restarts from RESET_PC with no partial valid.
